// File: rtl/skid_mc.sv
// skid_mc: multi-lane register FIFO whose upstream ready is a credit that can be
// retimed through FEED_STAGES registers; LOCKSTEP drives every lane from lane 0's control.
module skid_mc #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned CHANNELS    = 1,
   parameter int unsigned FEED_STAGES = 0,
   parameter int unsigned DEPTH       = 2 * FEED_STAGES + 2,
   parameter int unsigned LOCKSTEP    = 0
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [CHANNELS*DATA_WIDTH-1:0]         idat,
   input  logic [CHANNELS-1:0]                    ivld,
   output logic [CHANNELS-1:0]                    irdy,
   output logic [CHANNELS*DATA_WIDTH-1:0]         odat,
   output logic [CHANNELS-1:0]                    ovld,
   input  logic [CHANNELS-1:0]                    ordy,
   output logic [CHANNELS*$clog2(DEPTH+1)-1:0]    ocnt
);

   localparam int unsigned CW         = $clog2(DEPTH + 1);
   localparam int unsigned PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned GROUPS     = (LOCKSTEP != 0) ? 1 : CHANNELS;
   localparam int unsigned CREDIT_MAX =
      (DEPTH >= FEED_STAGES + 2) ? DEPTH - FEED_STAGES - 1 : 0;

   if (DEPTH < FEED_STAGES + 2) begin : g_depth_check
      $error("skid_mc: DEPTH must be at least FEED_STAGES+2");
   end

   logic [GROUPS-1:0]         grp_push, grp_vld, grp_rdy;
   logic [GROUPS-1:0][CW-1:0] grp_cnt;
   logic [GROUPS-1:0][PW-1:0] grp_wptr, grp_rptr;

   // In lockstep the upper ivld/ordy bits are intentionally ignored.
   logic unused_hs;
   assign unused_hs = ^{ivld, ordy};

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   for (genvar g = 0; g < GROUPS; g++) begin : g_ctl
      logic [CW-1:0] cnt_q, cnt_d;
      logic [PW-1:0] wptr_q, rptr_q;
      logic          push, pop, credit, vld, rdy;

      assign credit = (cnt_q <= CW'(CREDIT_MAX));
      assign vld    = (cnt_q != '0);
      assign push   = ivld[g] & rdy;
      assign pop    = vld & ordy[g];

      always_comb begin
         cnt_d = cnt_q;
         if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
         end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
         end else begin
            cnt_q <= cnt_d;
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
         end
      end

      if (FEED_STAGES == 0) begin : g_comb_rdy
         // Gate with reset so ready stays low while reset is held.
         assign rdy = credit & rst;
      end else begin : g_pipe_rdy
         logic [FEED_STAGES-1:0] feed_q, feed_d;

         always_comb begin
            feed_d    = feed_q << 1;
            feed_d[0] = credit;
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               feed_q <= '0;
            end else begin
               feed_q <= feed_d;
            end
         end

         assign rdy = feed_q[FEED_STAGES-1];
      end

      assign grp_push[g] = push;
      assign grp_vld[g]  = vld;
      assign grp_rdy[g]  = rdy;
      assign grp_cnt[g]  = cnt_q;
      assign grp_wptr[g] = wptr_q;
      assign grp_rptr[g] = rptr_q;

      a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
         !(push && !pop && (cnt_q == CW'(DEPTH))));
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      localparam int unsigned G = (LOCKSTEP != 0) ? 0 : k;
      logic [DATA_WIDTH-1:0] mem_q [DEPTH];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         end else if (grp_push[G]) begin
            mem_q[grp_wptr[G]] <= idat[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      assign odat[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[grp_rptr[G]];
      assign irdy[k]                          = grp_rdy[G];
      assign ovld[k]                          = grp_vld[G];
      assign ocnt[k*CW +: CW]                 = grp_cnt[G];
   end

endmodule
